// File: rtl/codein_pkg.sv
// Shared definitions for the compression-unit input unpacker.
package codein_pkg;

   localparam int unsigned WORD_W      = 64;
   localparam int unsigned HW_W        = 16;
   localparam int unsigned HW_PER_WORD = 4;
   localparam int unsigned CNT_W       = 2;
   localparam int unsigned DC_W        = 24;
   localparam int unsigned DC_ENCODE   = 5;
   localparam int unsigned DC_DECODE   = 6;
   localparam int unsigned FIFO_DEPTH  = 2;
   localparam int unsigned FIFO_CNT_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One buffered source word with its end-of-job marker.
   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } src_word_t;

   function automatic logic [HW_W-1:0] byte_swap(input logic [HW_W-1:0] d);
      return {d[7:0], d[15:8]};
   endfunction

endpackage

// File: rtl/codein_word_fifo2.sv
// Two-entry word buffer between the source port and the halfword unpacker.
module word_fifo2
   import codein_pkg::*;
(
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  src_word_t             wdata,
   output src_word_t             head,
   output logic                  full,
   output logic                  empty,
   output logic [FIFO_CNT_W-1:0] count
);

   src_word_t mem [FIFO_DEPTH];
   logic      wr_ptr;
   logic      rd_ptr;
   logic      do_push;
   logic      do_pop;

   assign do_pop  = pop & ~empty;
   // A write into a full buffer is only allowed when the head leaves that cycle.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/codein.sv
// Input unpacker: pops 64-bit source words and feeds 16-bit halfwords to the LZS engines.
module codein
   import codein_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)
(
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [DC_W-1:0]   dc,
   input  logic              m_enable,
   input  logic [WORD_W-1:0] m_src,
   input  logic              m_src_empty,
   input  logic              m_src_last,
   output wire               m_src_getn,
   output logic [HW_W-1:0]   src_data,
   output logic              en_in_valid,
   output logic              de_in_valid,
   input  logic              en_in_ready,
   input  logic              de_in_ready,
   output logic              src_last,
   output logic              src_done
);

   state_t                state;
   state_t                state_nxt;
   logic                  sel;
   logic                  enc;
   logic                  getn_r;
   logic                  wr_pending;
   logic                  inflight;
   logic                  pop_c;
   logic [CNT_W-1:0]      cnt;
   logic                  src_valid;
   logic                  ready;
   logic                  accept;
   logic                  head_pop;
   logic [31:0]           fill;
   logic [HW_W-1:0]       hw;
   src_word_t             wr_word;
   src_word_t             head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  unused_dc;

   assign unused_dc = ^{dc[DC_W-1:DC_DECODE+1], dc[DC_ENCODE-1:0]};

   assign sel = m_enable & (dc[DC_ENCODE] | dc[DC_DECODE]);
   assign enc = dc[DC_ENCODE];

   // The pop strobe is only driven while this port is granted.
   assign m_src_getn = sel ? getn_r : 1'bz;

   // A read is in flight from the pop cycle until its data is written.
   assign inflight = ~getn_r | wr_pending;
   assign fill     = 32'(fifo_count) + 32'(inflight);
   assign wr_word  = '{last: m_src_last, data: m_src};

   assign src_valid = ~fifo_empty & ((state == ST_RUN) | (state == ST_DRAIN));
   assign ready     = enc ? en_in_ready : de_in_ready;
   assign accept    = src_valid & ready;
   assign head_pop  = accept & (cnt == CNT_W'(HW_PER_WORD - 1));

   word_fifo2 u_fifo (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .flush    (~sel),
      .push     (wr_pending),
      .pop      (head_pop),
      .wdata    (wr_word),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Halfword cnt of the head word, bits [15:0] first.
   assign hw          = HW_W'(head.data >> (HW_W * 32'(cnt)));
   assign src_data    = enc ? byte_swap(hw) : hw;
   assign src_last    = src_valid & head.last & (cnt == CNT_W'(HW_PER_WORD - 1));
   assign en_in_valid = src_valid & enc;
   assign de_in_valid = src_valid & ~enc;
   assign src_done    = (state == ST_DONE);

   // Next state and pop decision.
   always_comb begin
      state_nxt = state;
      pop_c     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (sel) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            pop_c = ~m_src_empty & ~fifo_full & ~inflight & (fill < DEPTH);
            if (wr_pending & m_src_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (accept & src_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (!sel) state_nxt = ST_IDLE;
         end
      endcase
      if (!sel) begin
         state_nxt = ST_IDLE;
         pop_c     = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= ST_IDLE;
         getn_r     <= 1'b1;
         wr_pending <= 1'b0;
         cnt        <= '0;
      end else if (!sel) begin
         // Grant withdrawn: drop any in-flight read and restart unpacking.
         state      <= ST_IDLE;
         getn_r     <= 1'b1;
         wr_pending <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_nxt;
         getn_r     <= ~pop_c;
         wr_pending <= ~getn_r;
         if (accept) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_codein.sv
// Directed self-checking bench for the codein unpacker.
`timescale 1ns/1ps
module tb_codein;

   logic        wb_clk_i    = 1'b0;
   logic        wb_rst_i    = 1'b1;
   logic [23:0] dc          = '0;
   logic        m_enable    = 1'b0;
   logic [63:0] m_src       = '0;
   logic        m_src_empty;
   logic        m_src_last  = 1'b0;
   wire         m_src_getn;
   logic [15:0] src_data;
   logic        en_in_valid;
   logic        de_in_valid;
   logic        en_in_ready;
   logic        de_in_ready;
   logic        src_last;
   logic        src_done;
   logic        rdy         = 1'b0;

   pullup (m_src_getn);

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] words [3] = '{64'h0807060504030201, 64'h100F0E0D0C0B0A09,
                              64'h1817161514131211};
   int   nwords    = 2;
   int   avail     = 0;
   int   idx       = 0;
   int   pops      = 0;
   int   bad_pops  = 0;
   int   cyc       = 0;
   int   pop_cyc [3] = '{0, 0, 0};
   logic src_clear = 1'b0;

   codein dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .dc          (dc),
      .m_enable    (m_enable),
      .m_src       (m_src),
      .m_src_empty (m_src_empty),
      .m_src_last  (m_src_last),
      .m_src_getn  (m_src_getn),
      .src_data    (src_data),
      .en_in_valid (en_in_valid),
      .de_in_valid (de_in_valid),
      .en_in_ready (en_in_ready),
      .de_in_ready (de_in_ready),
      .src_last    (src_last),
      .src_done    (src_done)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   assign en_in_ready = dc[5] ? rdy : 1'b0;
   assign de_in_ready = dc[5] ? 1'b0 : rdy;
   assign m_src_empty = (idx >= avail);

   // Source port model: one-cycle read latency after a low pop strobe.
   always @(posedge wb_clk_i) begin
      cyc <= cyc + 1;
      if (src_clear) begin
         idx  <= 0;
         pops <= 0;
      end else if (m_src_getn === 1'b0) begin
         if (m_src_empty) bad_pops <= bad_pops + 1;
         m_src      <= (idx < 3) ? words[idx] : 64'h0;
         m_src_last <= (idx == nwords - 1);
         if (idx < 3) pop_cyc[idx] <= cyc;
         idx  <= idx + 1;
         pops <= pops + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Halfword k of the job: bytes 2k+1 (low) and 2k+2 (high) of the word table.
   function automatic logic [15:0] exp_hw(input bit enc, input int k);
      logic [7:0] lo;
      logic [7:0] hi;
      lo = 8'(2 * k + 1);
      hi = 8'(2 * k + 2);
      return enc ? {lo, hi} : {hi, lo};
   endfunction

   task automatic run_job(input bit enc, input int nw, input int avail0,
                          input int stall_at, input int gap_len, input int stop_at);
      int  k         = 0;
      int  budget    = 0;
      int  first_acc = -1;
      int  last_acc  = 0;
      bit  seen_v    = 1'b0;
      bit  plain     = (stall_at < 0) && (gap_len == 0);
      bit  gapped    = (gap_len > 0);
      logic v_mine;
      logic v_other;
      m_enable  = 1'b0;
      src_clear = 1'b1;
      @(negedge wb_clk_i);
      src_clear = 1'b0;
      nwords    = nw;
      avail     = avail0;
      dc        = enc ? 24'h000020 : 24'h000040;
      rdy       = 1'b1;
      m_enable  = 1'b1;
      while (k < nw * 4 && k != stop_at && budget < 300) begin
         @(negedge wb_clk_i);
         budget++;
         if (!seen_v && (en_in_valid || de_in_valid)) begin
            seen_v = 1'b1;
            chk("first_valid_latency", 64'(cyc - pop_cyc[0]), 64'd2);
         end
         if (k == stall_at) begin
            rdy = 1'b0;
            repeat (10) begin
               @(negedge wb_clk_i);
               chk("stall_hold_data", 64'(src_data), 64'(exp_hw(enc, k)));
               chk("stall_hold_valid", 64'(en_in_valid), 64'd1);
            end
            chk("stall_pops_bounded", 64'(pops), 64'd2);
            rdy      = 1'b1;
            stall_at = -1;
         end
         if (gap_len > 0 && k == 4) begin
            chk("gap_valid_low", 64'(en_in_valid | de_in_valid), 64'd0);
            repeat (gap_len) @(negedge wb_clk_i);
            chk("gap_no_pop", 64'(pops), 64'd1);
            chk("gap_still_low", 64'(en_in_valid | de_in_valid), 64'd0);
            avail   = nw;
            gap_len = 0;
         end
         v_mine  = enc ? en_in_valid : de_in_valid;
         v_other = enc ? de_in_valid : en_in_valid;
         if (v_mine && rdy) begin
            if (gapped && k == 4)
               chk("gap_resume_latency", 64'(cyc - pop_cyc[1]), 64'd2);
            chk("other_valid_low", 64'(v_other), 64'd0);
            chk(enc ? "enc_data" : "dec_data", 64'(src_data), 64'(exp_hw(enc, k)));
            chk("src_last", 64'(src_last), 64'(k == nw * 4 - 1));
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            k++;
         end
      end
      if (stop_at >= 0) begin
         chk("reached_abort_point", 64'(k), 64'(stop_at));
      end else begin
         chk("halfword_count", 64'(k), 64'(nw * 4));
         if (plain) chk("no_bubbles", 64'(last_acc - first_acc), 64'(nw * 4 - 1));
         @(negedge wb_clk_i);
         chk("src_done_set", 64'(src_done), 64'd1);
         chk("pop_count", 64'(pops), 64'(nw));
         chk("no_pop_while_empty", 64'(bad_pops), 64'd0);
         m_enable = 1'b0;
         @(negedge wb_clk_i);
         chk("src_done_clears", 64'(src_done), 64'd0);
         chk("getn_released", 64'(m_src_getn), 64'd1);
      end
   endtask

   initial begin
      #3;
      chk("rst_en_valid", 64'(en_in_valid), 64'd0);
      chk("rst_de_valid", 64'(de_in_valid), 64'd0);
      chk("rst_src_last", 64'(src_last), 64'd0);
      chk("rst_src_done", 64'(src_done), 64'd0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      // Encode and decode of the two-word job.
      run_job(1'b1, 2, 2, -1, 0, -1);
      run_job(1'b0, 2, 2, -1, 0, -1);

      // Ready held low at halfword 2 of a three-word job.
      run_job(1'b1, 3, 3, 2, 0, -1);

      // Source runs empty after word 1 for six cycles.
      run_job(1'b1, 2, 1, -1, 6, -1);

      // Grant withdrawn at halfword 5, then a clean restart.
      run_job(1'b1, 3, 3, -1, 0, 5);
      m_enable = 1'b0;
      @(negedge wb_clk_i);
      chk("flush_valid_low", 64'(en_in_valid | de_in_valid), 64'd0);
      chk("flush_getn_z", 64'(m_src_getn), 64'd1);
      chk("flush_src_last", 64'(src_last), 64'd0);
      chk("flush_src_done", 64'(src_done), 64'd0);
      run_job(1'b1, 2, 2, -1, 0, -1);

      // Asynchronous reset pulse at halfword 5.
      run_job(1'b1, 3, 3, -1, 0, 5);
      #1 wb_rst_i = 1'b1;
      #1;
      chk("arst_valid_low", 64'(en_in_valid | de_in_valid), 64'd0);
      chk("arst_getn_high", 64'(m_src_getn), 64'd1);
      chk("arst_src_last", 64'(src_last), 64'd0);
      chk("arst_src_done", 64'(src_done), 64'd0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      // Single word carrying the last flag.
      run_job(1'b1, 1, 1, -1, 0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
